// File: rtl/clock_set_ctrl_if.sv
// Bundle of the front-end inputs and counter-side outputs of clock_set_ctrl.
// master = timebase/button side, slave = the sequencer itself.
interface clock_set_ctrl_if;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic       maqm_incrementahora;
  logic       maqm_enable;
  logic       maqm_incremento;
  logic       hr_enable;
  logic       hr_incremento;
  logic [1:0] modo;
  logic [5:0] sec_count;
  logic       blink_h;
  logic       blink_m;

  modport master (
    output tick_1hz, btn_mode, btn_inc, maqm_incrementahora,
    input  maqm_enable, maqm_incremento, hr_enable, hr_incremento,
    input  modo, sec_count, blink_h, blink_m
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_inc, maqm_incrementahora,
    output maqm_enable, maqm_incremento, hr_enable, hr_incremento,
    output modo, sec_count, blink_h, blink_m
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Run/set-mode sequencer feeding the minute and hour counters of the digital clock.
// Define AUTO_REPEAT_EN to add hold-to-repeat on btn_inc while in a set mode.
module clock_set_ctrl #(
  parameter int SEC_PER_MIN = 60,
  parameter int HOLD_CYC    = 1000,
  parameter int REPEAT_CYC  = 250,
  parameter int CNT_W       = 16
) (
  input  logic            maqm_clock,
  input  logic            maqm_reset,
  clock_set_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    SET_H = 2'b01,
    SET_M = 2'b10
  } mode_t;

  localparam logic [5:0] SEC_LAST = 6'(SEC_PER_MIN - 1);

  if (SEC_PER_MIN < 1 || SEC_PER_MIN > 64 || HOLD_CYC < 1 || REPEAT_CYC < 1 ||
      CNT_W < 1 || (64'(1) << CNT_W) <= 64'(HOLD_CYC) ||
      (64'(1) << CNT_W) <= 64'(REPEAT_CYC)) begin : g_bad_param
    $error("clock_set_ctrl: parameter out of range");
  end

  mode_t      mode_reg;
  mode_t      mode_next;
  logic [5:0] sec_count_reg;
  logic       btn_mode_prev_reg;
  logic       btn_inc_prev_reg;
  logic       maqm_enable_reg;
  logic       hr_enable_reg;
  logic       maqm_incremento_reg;
  logic       hr_incremento_reg;
  logic       blink_h_reg;
  logic       blink_m_reg;

  logic mode_edge;
  logic inc_edge;
  logic repeat_fire;
  logic inc_fire;

  assign mode_edge = bus.btn_mode & ~btn_mode_prev_reg;
  assign inc_edge  = bus.btn_inc & ~btn_inc_prev_reg;
  // A mode change always swallows a coincident increment request.
  assign inc_fire  = (inc_edge | repeat_fire) & ~mode_edge;

  always_comb begin
    mode_next = RUN;
    case (mode_reg)
      RUN:     mode_next = mode_edge ? SET_H : RUN;
      SET_H:   mode_next = mode_edge ? SET_M : SET_H;
      SET_M:   mode_next = mode_edge ? RUN   : SET_M;
      default: mode_next = RUN;
    endcase
  end

`ifdef AUTO_REPEAT_EN
  logic [CNT_W-1:0] hold_cnt_reg;
  logic             repeat_phase_reg;
  logic             set_mode;

  assign set_mode = (mode_reg == SET_H) || (mode_reg == SET_M);

  // hold_cnt_reg == 0 means idle; it is armed only by a genuine rising edge.
  assign repeat_fire = set_mode && bus.btn_inc && !inc_edge && (hold_cnt_reg != '0) &&
                       (repeat_phase_reg ? (hold_cnt_reg == CNT_W'(REPEAT_CYC))
                                         : (hold_cnt_reg == CNT_W'(HOLD_CYC)));

  always_ff @(posedge maqm_clock or negedge maqm_reset) begin
    if (!maqm_reset) begin
      hold_cnt_reg     <= '0;
      repeat_phase_reg <= 1'b0;
    end else if (!bus.btn_inc || mode_edge || !set_mode) begin
      hold_cnt_reg     <= '0;
      repeat_phase_reg <= 1'b0;
    end else if (inc_edge) begin
      hold_cnt_reg     <= CNT_W'(1);
      repeat_phase_reg <= 1'b0;
    end else if (repeat_fire) begin
      hold_cnt_reg     <= CNT_W'(1);
      repeat_phase_reg <= 1'b1;
    end else if (hold_cnt_reg != '0) begin
      hold_cnt_reg     <= hold_cnt_reg + 1'b1;
    end
  end
`else
  assign repeat_fire = 1'b0;
`endif

  always_ff @(posedge maqm_clock or negedge maqm_reset) begin
    if (!maqm_reset) begin
      mode_reg            <= RUN;
      sec_count_reg       <= '0;
      btn_mode_prev_reg   <= 1'b0;
      btn_inc_prev_reg    <= 1'b0;
      maqm_enable_reg     <= 1'b1;
      hr_enable_reg       <= 1'b1;
      maqm_incremento_reg <= 1'b0;
      hr_incremento_reg   <= 1'b0;
      blink_h_reg         <= 1'b0;
      blink_m_reg         <= 1'b0;
    end else begin
      btn_mode_prev_reg   <= bus.btn_mode;
      btn_inc_prev_reg    <= bus.btn_inc;
      maqm_incremento_reg <= 1'b0;
      hr_incremento_reg   <= 1'b0;
      mode_reg            <= mode_next;
      maqm_enable_reg     <= (mode_next != SET_H);
      hr_enable_reg       <= (mode_next != SET_M);

      case (mode_reg)
        RUN: begin
          blink_h_reg <= 1'b0;
          blink_m_reg <= 1'b0;
          if (bus.tick_1hz) begin
            if (sec_count_reg >= SEC_LAST) begin
              sec_count_reg       <= '0;
              maqm_incremento_reg <= 1'b1;
              hr_incremento_reg   <= bus.maqm_incrementahora;
            end else begin
              sec_count_reg <= sec_count_reg + 1'b1;
            end
          end
        end
        SET_H: begin
          sec_count_reg <= '0;
          blink_m_reg   <= 1'b0;
          if (bus.tick_1hz) blink_h_reg <= ~blink_h_reg;
          if (inc_fire) hr_incremento_reg <= 1'b1;
        end
        SET_M: begin
          // Hour carry stays gated here so minute setting never moves the hours.
          sec_count_reg <= '0;
          blink_h_reg   <= 1'b0;
          if (bus.tick_1hz) blink_m_reg <= ~blink_m_reg;
          if (inc_fire) maqm_incremento_reg <= 1'b1;
        end
        default: begin
          sec_count_reg <= '0;
          blink_h_reg   <= 1'b0;
          blink_m_reg   <= 1'b0;
        end
      endcase

      if (mode_edge) begin
        sec_count_reg <= '0;
        blink_h_reg   <= 1'b0;
        blink_m_reg   <= 1'b0;
      end
    end
  end

  assign bus.modo            = mode_reg;
  assign bus.sec_count       = sec_count_reg;
  assign bus.maqm_enable     = maqm_enable_reg;
  assign bus.hr_enable       = hr_enable_reg;
  assign bus.maqm_incremento = maqm_incremento_reg;
  assign bus.hr_incremento   = hr_incremento_reg;
  assign bus.blink_h         = blink_h_reg;
  assign bus.blink_m         = blink_m_reg;

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Mode and increment sequencer for the digital clock's minute and hour counters.
- Turns a 1 Hz tick into minute pulses in run mode.
- Provides a set-hours / set-minutes user mode driven by two buttons, and gates hour carries so that setting minutes never disturbs hours.
- Sits between the timebase/button front-end and the minute/hour counter instances.

Parameters:
- SEC_PER_MIN, 60: tick_1hz pulses per minute pulse.
- HOLD_CYC, 1000: clock cycles btn_inc must stay high before auto-repeat starts.
- REPEAT_CYC, 250: clock cycles between auto-repeat pulses.
- CNT_W, 16: width of the hold/repeat cycle counter. Must hold max(HOLD_CYC, REPEAT_CYC).

Ports:
- maqm_clock  in  1  system clock.
- maqm_reset  in  1  asynchronous active-low reset.
- tick_1hz  in  1  one-cycle pulse per second.
- btn_mode  in  1  mode button, level, already synchronized and debounced.
- btn_inc  in  1  increment button, level, already synchronized and debounced.
- maqm_incrementahora  in  1  carry flag from the minute counter (high while minutes = 59).
- maqm_enable  out  1  minute counter enable.
- maqm_incremento  out  1  minute increment pulse.
- hr_enable  out  1  hour counter enable.
- hr_incremento  out  1  hour increment pulse.
- modo  out  2  current mode: 00 RUN, 01 SET_H, 10 SET_M.
- sec_count  out  6  seconds within the current minute.
- blink_h  out  1  hour-digit blank request.
- blink_m  out  1  minute-digit blank request.

Behaviour:
- Reset, maqm_reset low, asynchronous:
  - modo = RUN, sec_count = 0.
  - maqm_incremento = 0, hr_incremento = 0.
  - blink_h = 0, blink_m = 0.
  - Button edge registers = 0, hold counter = 0.
  - A reset asserted mid-operation (mid-hold, mid-minute) returns every output to these values with no partial pulse.
- All outputs are registered. Every pulse is exactly one cycle wide, asserted the cycle after its cause.
- Rising-edge detection on btn_mode and btn_inc uses a previous-value register.
- FSM, advanced by a btn_mode rising edge: RUN -> SET_H -> SET_M -> RUN.
- Enables by mode:
  - maqm_enable = 1 in RUN and SET_M, 0 in SET_H.
  - hr_enable = 1 in RUN and SET_H, 0 in SET_M.
- RUN:
  - On tick_1hz, sec_count increments.
  - At SEC_PER_MIN-1, a tick wraps sec_count to 0 and asserts maqm_incremento.
  - hr_incremento is asserted in the same cycle only if maqm_incrementahora = 1.
  - btn_inc is ignored.
- SET_H:
  - sec_count is forced to 0 on entry and held at 0.
  - tick_1hz produces no minute pulse.
  - A btn_inc rising edge produces one hr_incremento pulse. maqm_incremento stays 0.
- SET_M:
  - A btn_inc rising edge produces one maqm_incremento pulse.
  - hr_incremento stays 0, even when the minute counter wraps 59 -> 00.
- Returning SET_M -> RUN: sec_count starts from 0.
- Blink:
  - In SET_H, blink_h toggles on each tick_1hz. In SET_M, blink_m toggles on each tick_1hz.
  - Both blink outputs are 0 in RUN.
  - Both blink outputs clear on any mode change.
- Simultaneous events:
  - btn_mode edge with btn_inc edge or repeat: the mode change wins and no increment pulse is issued.
  - btn_mode edge with a RUN minute wrap: the RUN minute pulse is still issued, then the mode changes.
  - Hold counter clears on a mode change and on btn_inc low.
- sec_count width is 6 bits; SEC_PER_MIN must not exceed 64.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- With the macro defined, in SET_H/SET_M:
  - Holding btn_inc high for HOLD_CYC cycles after its rising edge issues an extra increment pulse.
  - Further pulses follow every REPEAT_CYC cycles while btn_inc stays high.
  - Releasing btn_inc stops repeating immediately.
- Without the macro: exactly one pulse per btn_inc rising edge, and the hold counter logic is absent.

Test Plan:
- Reset, then 60 tick_1hz pulses in RUN -> sec_count 0..59 -> 0; exactly one maqm_incremento pulse, on the cycle after the 60th tick; hr_incremento = 0 while maqm_incrementahora = 0.
- RUN with maqm_incrementahora = 1 at the 60th tick -> maqm_incremento and hr_incremento pulse in the same cycle.
- Three btn_mode presses -> modo 01, 10, 00; maqm_enable 0, 1, 1; hr_enable 1, 0, 1; sec_count = 0 on return to RUN.
- SET_M, 5 btn_inc presses with maqm_incrementahora = 1 -> 5 maqm_incremento pulses, 0 hr_incremento; 10 ticks in SET_M -> blink_m toggles 10 times, no minute pulses.
- btn_mode and btn_inc rising in the same cycle in SET_H -> modo = 10, no hr_incremento.
- With AUTO_REPEAT_EN, HOLD_CYC = 20, REPEAT_CYC = 5, btn_inc held 40 cycles in SET_H -> pulses at cycles 1, 21, 26, 31, 36 after press; none after release. Without the macro -> a single pulse. Reset asserted at cycle 23 -> all outputs at reset values, no further pulses.
